// File: rtl/dram_frame_writer.sv
// dram_frame_writer: packs pairs of 8-bit pixels into 16-bit words and queues
// them in a first-word-fall-through FIFO for the DRAM frame-buffer write port.
// An overrun drops the rest of the frame until the next h=0, v=0 pixel.
module dram_frame_writer #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk_pixel,
  input  logic                          rst_n,
  input  logic                          active_draw,
  input  logic [10:0]                   h_count,
  input  logic [9:0]                    v_count,
  input  logic [7:0]                    intensity,
  input  logic                          dram_write_ready,
  output logic                          dram_write_valid,
  output logic [15:0]                   dram_write_data,
  output logic                          dram_write_last,
  output logic                          dram_write_sof,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [10:0]   H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]    V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    CAPTURE,
    DROP_FRAME
  } state_t;

  state_t        state, state_next;
  logic [7:0]    low_byte, low_byte_next;
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          accept, frame_start, fifo_full, fifo_empty;
  logic          push, pop, reject;
  logic [17:0]   push_word, head_word;

  // Counts outside the active window are ignored even if qualified, so a
  // misbehaving timing generator cannot corrupt the packing.
  assign accept      = active_draw && (h_count <= H_LAST) && (v_count <= V_LAST);
  assign frame_start = accept && (h_count == 11'd0) && (v_count == 10'd0);
  assign fifo_full   = (level == FULL_LEVEL);
  assign fifo_empty  = (level == '0);
  assign pop         = !fifo_empty && dram_write_ready;
  assign push_word   = {intensity, low_byte, (h_count == H_LAST),
                        (h_count == 11'd1) && (v_count == 10'd0)};

  // Next-state and packing decisions; a pop in the same cycle frees a slot,
  // so a full FIFO only rejects when the sink is stalled.
  always_comb begin
    state_next    = state;
    low_byte_next = low_byte;
    push          = 1'b0;
    reject        = 1'b0;
    case (state)
      WAIT_FRAME, DROP_FRAME: begin
        if (frame_start) begin
          state_next    = CAPTURE;
          low_byte_next = intensity;
        end
      end
      CAPTURE: begin
        if (accept) begin
          if (!h_count[0]) begin
            low_byte_next = intensity;
          end else if (fifo_full && !pop) begin
            reject     = 1'b1;
            state_next = DROP_FRAME;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_next = WAIT_FRAME;
    endcase
  end

  // FSM, pending low byte and sticky overrun flag.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_FRAME;
      low_byte <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      low_byte <= low_byte_next;
      if (reject) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are qualified by the level, so no reset is needed.
  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Pointers and occupancy; push and pop together leave the level unchanged.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Head entry is masked while empty so the port reads zero after reset.
  assign head_word        = fifo_empty ? 18'd0 : mem[rd_ptr];
  assign dram_write_valid = !fifo_empty;
  assign dram_write_data  = head_word[17:2];
  assign dram_write_last  = head_word[1];
  assign dram_write_sof   = head_word[0];
  assign fifo_level       = level;

endmodule
